// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port 256x32 word memory (combinational read, write on
//   posedge clk) between two requesters with round-robin arbitration.
//   Partial-byte stores are performed as a read-modify-write over two cycles.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   pN_valid/ready               request handshake (N = 0 core, 1 debug/DMA)
//   pN_we/addr/wdata/be          request fields (byte address, byte enables)
//   pN_resp_valid/rdata/err      one-cycle response pulse, one cycle after accept
//                                (two cycles for partial stores)
//   mem_we/addr/wdata/rdata      attached memory interface
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 256,
    parameter bit RESET_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {IDLE, RMW} state_t;

    state_t            state;
    logic              last_grant;
    logic              gnt;
    logic              accept;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    logic              in_range;
    logic              full_store;
    logic              part_store;
    logic [31:0]       be_mask;
    logic [31:0]       merged;
    logic [29:0]       rmw_idx;
    logic [31:0]       rmw_data;
    logic              rmw_port;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_err;
    logic [1:0][31:0]  resp_rdata;
    logic              unused_bits;

    // Contended grant goes to the port that did not win last time.
    always_comb begin
        gnt = 1'b0;
        if (p0_valid && p1_valid) gnt = ~last_grant;
        else if (p1_valid)        gnt = 1'b1;
    end

    assign accept   = (state == IDLE) && !rst && (p0_valid || p1_valid);
    assign p0_ready = accept && !gnt;
    assign p1_ready = accept && gnt;

    assign sel_we    = gnt ? p1_we    : p0_we;
    assign sel_addr  = gnt ? p1_addr  : p0_addr;
    assign sel_wdata = gnt ? p1_wdata : p0_wdata;
    assign sel_be    = gnt ? p1_be    : p0_be;

    assign in_range   = sel_addr[31:2] < 30'(DEPTH_WORDS);
    assign full_store = sel_we && (sel_be == 4'hF);
    assign part_store = sel_we && (sel_be != 4'h0) && (sel_be != 4'hF);

    always_comb begin
        for (int k = 0; k < 4; k++) be_mask[8*k +: 8] = {8{sel_be[k]}};
    end
    assign merged = (sel_wdata & be_mask) | (mem_rdata & ~be_mask);

    // Byte-address low bits are ignored by design.
    assign unused_bits = &{1'b0, sel_addr[1:0]};

    // Memory drive: the RMW write is suppressed while reset is asserted so a
    // reset landing in the RMW cycle aborts the merge.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (state == RMW) begin
            if (!rst) begin
                mem_we    = 1'b1;
                mem_addr  = {rmw_idx, 2'b00};
                mem_wdata = rmw_data;
            end
        end else if (accept && in_range && (!sel_we || sel_be != 4'h0)) begin
            mem_addr = {sel_addr[31:2], 2'b00};
            if (full_store) begin
                mem_we    = 1'b1;
                mem_wdata = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ~RESET_PRIO;
            rmw_idx    <= '0;
            rmw_data   <= '0;
            rmw_port   <= 1'b0;
            resp_valid <= '0;
            resp_err   <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= '0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt;
                        if (in_range && part_store) begin
                            state    <= RMW;
                            rmw_idx  <= sel_addr[31:2];
                            rmw_data <= merged;
                            rmw_port <= gnt;
                        end else begin
                            resp_valid[gnt] <= 1'b1;
                            resp_err[gnt]   <= !in_range;
                            resp_rdata[gnt] <= (in_range && !sel_we) ? mem_rdata : 32'h0;
                        end
                    end
                end
                RMW: begin
                    state                <= IDLE;
                    resp_valid[rmw_port] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p0_resp_valid = resp_valid[0];
    assign p0_resp_err   = resp_err[0];
    assign p0_resp_rdata = resp_rdata[0];
    assign p1_resp_valid = resp_valid[1];
    assign p1_resp_err   = resp_err[1];
    assign p1_resp_rdata = resp_rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios followed by randomized traffic, checked against a
//   transaction-level reference model (word array + grant/response rules).
module tb_dmem_arbiter;
    localparam bit RP = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we, p0_resp_valid, p0_resp_err;
    logic [31:0] p0_addr, p0_wdata, p0_resp_rdata;
    logic [3:0]  p0_be;
    logic        p1_valid, p1_ready, p1_we, p1_resp_valid, p1_resp_err;
    logic [31:0] p1_addr, p1_wdata, p1_resp_rdata;
    logic [3:0]  p1_be;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    int          vectors = 0;
    int          errors  = 0;
    int          last_g;
    bit          busy;
    int          rmw_port_m;
    int          rmw_idx_m;
    logic [31:0] rmw_val;
    int          acc_port;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    dmem_arbiter #(.DEPTH_WORDS(256), .RESET_PRIO(RP)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_resp_valid(p0_resp_valid),
        .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_resp_valid(p1_resp_valid),
        .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) if (be[k]) m = m | (32'hFF << (8 * k));
        return (wd & m) | (old & ~m);
    endfunction

    task automatic req(input int p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        if (p == 0) begin
            p0_valid = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd; p0_be = be;
        end else begin
            p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; p1_be = be;
        end
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        logic [3:0]  be;
        int          r;
        r = int'($urandom_range(0, 7));
        if (r == 0)      a = 32'h400 + ($urandom_range(0, 63) << 2);
        else if (r == 1) a = $urandom | 32'h8000_0000;
        else             a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        r = int'($urandom_range(0, 3));
        be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        req(p, 1'($urandom_range(0, 1)), a, $urandom, be);
    endtask

    // One clock cycle: check combinational outputs, clock, apply memory
    // write, advance the model, check responses.
    task automatic step();
        bit          acc, we, inr, exp_we;
        int          g, idx;
        logic [31:0] a, wd;
        logic [3:0]  be;
        bit   [1:0]  nv, ne;
        logic [31:0] nrd [2];
        bit          wr_en;
        logic [7:0]  wr_idx;
        logic [31:0] wr_dat;
        #1;
        acc = 1'b0; g = 0;
        if (!rst && !busy) begin
            if (p0_valid && p1_valid) begin acc = 1'b1; g = 1 - last_g; end
            else if (p0_valid)        begin acc = 1'b1; g = 0; end
            else if (p1_valid)        begin acc = 1'b1; g = 1; end
        end
        we  = (g == 0) ? p0_we    : p1_we;
        a   = (g == 0) ? p0_addr  : p1_addr;
        wd  = (g == 0) ? p0_wdata : p1_wdata;
        be  = (g == 0) ? p0_be    : p1_be;
        inr = (a[31:2] < 30'd256);
        idx = int'(a[9:2]);
        chk("p0_ready", 32'(p0_ready), 32'(acc && g == 0));
        chk("p1_ready", 32'(p1_ready), 32'(acc && g == 1));
        exp_we = !rst && (busy || (acc && we && inr && be == 4'hF));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("mem_addr", mem_addr, busy ? 32'(rmw_idx_m * 4) : {a[31:2], 2'b00});
            chk("mem_wdata", mem_wdata, busy ? rmw_val : wd);
        end
        wr_en = mem_we; wr_idx = mem_addr[9:2]; wr_dat = mem_wdata;
        @(posedge clk);
        #1;
        if (wr_en) mem[wr_idx] = wr_dat;
        nv = '0; ne = '0; nrd[0] = 32'h0; nrd[1] = 32'h0;
        acc_port = -1;
        if (rst) begin
            busy = 1'b0;
            last_g = 1 - int'(RP);
        end else if (busy) begin
            ref_mem[rmw_idx_m] = rmw_val;
            nv[rmw_port_m] = 1'b1;
            busy = 1'b0;
        end else if (acc) begin
            acc_port = g;
            last_g = g;
            if (!inr) begin
                nv[g] = 1'b1; ne[g] = 1'b1;
            end else if (!we) begin
                nv[g] = 1'b1; nrd[g] = ref_mem[idx];
            end else if (be == 4'hF) begin
                ref_mem[idx] = wd; nv[g] = 1'b1;
            end else if (be == 4'h0) begin
                nv[g] = 1'b1;
            end else begin
                busy = 1'b1; rmw_port_m = g; rmw_idx_m = idx;
                rmw_val = merge(ref_mem[idx], wd, be);
            end
        end
        @(negedge clk);
        chk("p0_resp_valid", 32'(p0_resp_valid), 32'(nv[0]));
        chk("p1_resp_valid", 32'(p1_resp_valid), 32'(nv[1]));
        if (nv[0] || rst) begin
            chk("p0_resp_rdata", p0_resp_rdata, nrd[0]);
            chk("p0_resp_err", 32'(p0_resp_err), 32'(ne[0]));
        end
        if (nv[1] || rst) begin
            chk("p1_resp_rdata", p1_resp_rdata, nrd[1]);
            chk("p1_resp_err", 32'(p1_resp_err), 32'(ne[1]));
        end
    endtask

    initial begin
        logic [31:0] saved;
        rst = 1'b1;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
        busy = 1'b0; last_g = 1 - int'(RP); acc_port = -1;
        rmw_port_m = 0; rmw_idx_m = 0; rmw_val = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;

        // reset state
        step();
        rst = 1'b0;

        // full store then load back
        req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        step();
        req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        chk("t1_rdata", p0_resp_rdata, 32'hDEAD_BEEF);
        p0_valid = 1'b0;

        // partial store from p1, p0 held off during RMW
        req(1, 1'b1, 32'h20, 32'h0000_AA00, 4'b0010);
        step();
        p1_valid = 1'b0;
        req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        step();
        chk("t2_word", mem[8], 32'h1122_AA44);
        step();
        chk("t2_load", p0_resp_rdata, 32'h1122_AA44);
        p0_valid = 1'b0;

        // alternating grants under constant contention from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!p0_valid) req(0, 1'b0, 32'($urandom_range(0, 255) * 4), 32'h0, 4'h0);
            if (!p1_valid) req(1, 1'b0, 32'($urandom_range(0, 255) * 4), 32'h0, 4'h0);
            step();
            chk("t3_grant", 32'(acc_port), 32'(i % 2));
            if (acc_port == 0) p0_valid = 1'b0;
            if (acc_port == 1) p1_valid = 1'b0;
        end
        p0_valid = 1'b0; p1_valid = 1'b0;

        // out-of-range load
        req(0, 1'b0, 32'h400, 32'h0, 4'h0);
        step();
        chk("t4_err", 32'(p0_resp_err), 32'h1);
        chk("t4_rdata", p0_resp_rdata, 32'h0);
        p0_valid = 1'b0;

        // reset during the RMW cycle aborts the merge
        saved = mem[12];
        req(0, 1'b1, 32'h30, 32'h5555_5555, 4'b0001);
        step();
        p0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_word", mem[12], saved);
        req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        step();
        chk("t5_idle_accept", 32'(acc_port), 32'h1);
        p1_valid = 1'b0;

        // zero byte-enable store is a no-op
        saved = mem[16];
        req(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0);
        step();
        chk("t6_ack", 32'(p0_resp_valid), 32'h1);
        chk("t6_word", mem[16], saved);
        p0_valid = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!p0_valid && $urandom_range(0, 3) != 0) rand_req(0);
            if (!p1_valid && $urandom_range(0, 3) != 0) rand_req(1);
            if ($urandom_range(0, 63) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
            if (acc_port == 0) p0_valid = 1'b0;
            if (acc_port == 1) p1_valid = 1'b0;
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        step();
        step();

        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
